// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: frame tick, game FSM, button edges, flap and score control; HIGH_SCORE_EN adds a high-score register.
module flappy_game_ctrl #(
  parameter int TICK_DIV     = 833333,
  parameter int FLOOR_Y      = 460,
  parameter int DEATH_FRAMES = 30,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flap_btn,
  input  logic [10:0]        bird_y,
  input  logic               pipe_hit,
  input  logic               pipe_passed,
  output logic               frame_tick,
  output logic               phys_enable,
  output logic               game_reset,
  output logic               flap,
  output logic               collision,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEATH_FRAMES + 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DYING = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [DW-1:0]      death_q, death_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_q, flap_btn_q, flap_pend_q, flap_pend_d;
  logic               start_edge, flap_edge, hit, death_done;

  assign frame_tick = tick_q == TW'(TICK_DIV - 1);
  assign start_edge = start & ~start_q;
  assign flap_edge  = flap_btn & ~flap_btn_q;
  // bit 10 set means the bird underflowed above the top of the screen
  assign hit        = pipe_hit | (bird_y >= 11'(FLOOR_Y)) | bird_y[10];
  assign death_done = (state_q == S_DYING) && frame_tick && (death_q == DW'(DEATH_FRAMES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_edge ? S_READY : S_IDLE;
      S_READY: state_d = flap_edge ? S_PLAY : S_READY;
      S_PLAY:  state_d = hit ? S_DYING : S_PLAY;
      S_DYING: state_d = death_done ? S_OVER : S_DYING;
      S_OVER:  state_d = start_edge ? S_READY : S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_d      = frame_tick ? '0 : tick_q + 1'b1;
    death_d     = (state_q != S_DYING) ? '0 : death_q + DW'(frame_tick);
    flap_pend_d = (state_d != S_PLAY) ? 1'b0 : flap_edge ? 1'b1 : frame_tick ? 1'b0 : flap_pend_q;
    score_d     = (state_q != S_READY && state_d == S_READY) ? '0 :
                  (state_q == S_PLAY && pipe_passed && !hit && score_q != '1) ? score_q + 1'b1 : score_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      death_q     <= '0;
      score_q     <= '0;
      start_q     <= 1'b1;
      flap_btn_q  <= 1'b1;
      flap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      death_q     <= death_d;
      score_q     <= score_d;
      start_q     <= start;
      flap_btn_q  <= flap_btn;
      flap_pend_q <= flap_pend_d;
    end
  end

  assign game_reset  = (state_q == S_IDLE) || (state_q == S_READY);
  assign phys_enable = state_q == S_PLAY;
  assign collision   = (state_q == S_DYING) || (state_q == S_OVER);
  assign game_over   = state_q == S_OVER;
  assign flap        = frame_tick & flap_pend_q;
  assign score       = score_q;

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) high_q <= '0;
    else if (death_done && score_q > high_q) high_q <= score_q;
  end

  assign high_score = high_q;
`else
  assign high_score = '0;
`endif
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed and randomized stimulus, reference model feeding a scoreboard queue.
module tb_flappy_game_ctrl;
  localparam int TD = 4;
  localparam int DF = 3;
  localparam int FY = 460;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  typedef struct packed {
    logic          tick;
    logic          phys;
    logic          grst;
    logic          flp;
    logic          coll;
    logic          gover;
    logic [SW-1:0] sc;
    logic [SW-1:0] hi;
  } outs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b1;
  logic          flap_btn = 1'b0;
  logic [10:0]   bird_y = 11'd200;
  logic          pipe_hit = 1'b0;
  logic          pipe_passed = 1'b0;
  logic          frame_tick, phys_enable, game_reset, flap, collision, game_over;
  logic [SW-1:0] score, high_score;

  flappy_game_ctrl #(.TICK_DIV(TD), .FLOOR_Y(FY), .DEATH_FRAMES(DF), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .flap_btn(flap_btn), .bird_y(bird_y),
    .pipe_hit(pipe_hit), .pipe_passed(pipe_passed), .frame_tick(frame_tick),
    .phys_enable(phys_enable), .game_reset(game_reset), .flap(flap), .collision(collision),
    .game_over(game_over), .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  outs_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int ph, n, sc, hi, dticks;
  bit ps, pf, pend;

  function automatic outs_t expected();
    outs_t e;
    e.tick  = (n % TD) == TD - 1;
    e.phys  = ph == 2;
    e.grst  = ph <= 1;
    e.flp   = e.tick && pend && ph == 2;
    e.coll  = ph >= 3;
    e.gover = ph == 4;
    e.sc    = SW'(sc);
    e.hi    = SW'(hi);
    return e;
  endfunction

  task automatic model_reset();
    ph = 0; n = 0; sc = 0; hi = 0; dticks = 0; ps = 1; pf = 1; pend = 0;
    exp_q.delete();
    exp_q.push_back(expected());
  endtask

  task automatic model_step();
    bit tk, se, fe, hit;
    int nph;
    tk  = (n % TD) == TD - 1;
    se  = start && !ps;
    fe  = flap_btn && !pf;
    hit = pipe_hit || (int'(bird_y) >= FY) || bird_y[10];
    nph = ph;
    case (ph)
      0: if (se) nph = 1;
      1: if (fe) nph = 2;
      2: begin
        if (pipe_passed && !hit && sc < SMAX) sc++;
        if (hit) nph = 3;
      end
      3: if (tk) begin
        dticks++;
        if (dticks == DF) begin
          nph = 4;
`ifdef HIGH_SCORE_EN
          if (sc > hi) hi = sc;
`endif
        end
      end
      default: if (se) nph = 1;
    endcase
    if (nph == 1 && ph != 1) sc = 0;
    if (nph == 3 && ph != 3) dticks = 0;
    if (nph != 2) pend = 0;
    else if (fe) pend = 1;
    else if (tk) pend = 0;
    ph = nph; n++; ps = start; pf = flap_btn;
    exp_q.push_back(expected());
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    outs_t e, g;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{frame_tick, phys_enable, game_reset, flap, collision, game_over, score, high_score};
      checks++;
      if (g === e) passes++;
      else $display("FAIL outs t=%0t got tick=%b phys=%b grst=%b flap=%b coll=%b over=%b score=%0d high=%0d required tick=%b phys=%b grst=%b flap=%b coll=%b over=%b score=%0d high=%0d",
                    $time, g.tick, g.phys, g.grst, g.flp, g.coll, g.gover, g.sc, g.hi,
                    e.tick, e.phys, e.grst, e.flp, e.coll, e.gover, e.sc, e.hi);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t: simulation did not finish, %0d/%0d checks passed", $time, passes, checks);
    $finish;
  end

  task automatic check_reset();
    outs_t g, e;
    g = '{frame_tick, phys_enable, game_reset, flap, collision, game_over, score, high_score};
    e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SW'(0), SW'(0)};
    checks++;
    if (g === e) passes++;
    else $display("FAIL reset t=%0t got tick=%b phys=%b grst=%b flap=%b coll=%b over=%b score=%0d high=%0d required reset values",
                  $time, g.tick, g.phys, g.grst, g.flp, g.coll, g.gover, g.sc, g.hi);
  endtask

  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    start = 1'b0; cyc(); start = 1'b1; cyc(); start = 1'b0; cyc();
  endtask

  task automatic press_flap();
    flap_btn = 1'b1; cyc(); flap_btn = 1'b0; cyc();
  endtask

  task automatic passes_n(input int k);
    repeat (k) begin
      pipe_passed = 1'b1; cyc(); pipe_passed = 1'b0; cyc();
    end
  endtask

  task automatic die_and_wait();
    pipe_hit = 1'b1; cyc(); pipe_hit = 1'b0; cyc(DF * TD + 4);
  endtask

  initial begin
    cyc(3);
    check_reset();
    reset = 1'b0;
    cyc(9);
    press_start();
    cyc(3);
    press_flap();
    cyc(6);
    repeat (3) press_flap();
    cyc(5);
    passes_n(3);
    die_and_wait();
    press_start(); press_flap(); cyc(2);
    bird_y = 11'd460; pipe_passed = 1'b1; cyc();
    bird_y = 11'd200; pipe_passed = 1'b0; cyc(DF * TD + 4);
    press_start(); press_flap(); cyc(2);
    bird_y = 11'h7FE; cyc();
    bird_y = 11'd200; cyc(DF * TD + 4);
    press_start(); press_flap();
    passes_n(17);
    die_and_wait();
    press_start(); press_flap();
    passes_n(2);
    die_and_wait();
    for (int i = 0; i < 3000; i++) begin
      int r;
      start       = $urandom_range(0, 5) == 0;
      flap_btn    = $urandom_range(0, 2) == 0;
      pipe_hit    = $urandom_range(0, 59) == 0;
      pipe_passed = $urandom_range(0, 5) == 0;
      r = $urandom_range(0, 99);
      bird_y = (r < 3) ? 11'd460 : (r < 5) ? 11'h7FE : (r < 7) ? 11'd459 : 11'(100 + $urandom_range(0, 300));
      reset  = $urandom_range(0, 799) == 0;
      cyc();
      reset = 1'b0;
    end
    start = 1'b0; flap_btn = 1'b0; pipe_hit = 1'b0; pipe_passed = 1'b0; bird_y = 11'd200;
    cyc(2);
    press_start(); press_flap(); cyc(3);
    pipe_hit = 1'b1; cyc(); pipe_hit = 1'b0; cyc(2);
    reset = 1'b1; #2;
    check_reset();
    cyc(2);
    reset = 1'b0;
    cyc(6);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Top-level game sequencer for the flappy-bird datapath. Owns the frame-rate tick, the game state machine (idle, ready, play, dying, over), and button edge detection. Drives the bird physics block's `enable`, `game_reset`, `flap` and `collision` inputs, and keeps the score. Sits between the board buttons and pipe/overlap logic on one side and the physics and VGA render blocks on the other.

## Interface
Parameters:
- `TICK_DIV`, 833333: clock cycles per frame tick (60 Hz at 50 MHz); legal range ≥2.
- `FLOOR_Y`, 460: bird at or below the floor when `bird_y >= FLOOR_Y`.
- `DEATH_FRAMES`, 30: frame ticks spent in DYING before OVER; legal range ≥1.
- `SCORE_W`, 10: score width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: start/restart button level, already synchronized.
- `flap_btn` in 1: flap button level, already synchronized.
- `bird_y` in 11: bird vertical position from physics.
- `pipe_hit` in 1: level, bird overlaps a pipe.
- `pipe_passed` in 1: one-cycle pulse when a pipe crosses the bird column.
- `frame_tick` out 1: one-cycle pulse, once every `TICK_DIV` cycles.
- `phys_enable` out 1: to physics `enable`.
- `game_reset` out 1: to physics `game_reset`.
- `flap` out 1: one-cycle flap pulse to physics.
- `collision` out 1: to physics `collision` (freezes the bird).
- `game_over` out 1: high in OVER.
- `score` out `SCORE_W`: pipes passed in the current game.
- `high_score` out `SCORE_W`: best score (see Configuration).

## Operation
- Tick counter: free-running, counts 0 to `TICK_DIV-1` and wraps. `frame_tick` is 1 when the count equals `TICK_DIV-1`. It runs in every state.
- Edge detect: one previous-value register each for `start` and `flap_btn`, reset to 1.
  - `start_edge = start & ~start_q`; same form for `flap_edge`.
  - A button held through reset produces no edge.
- States and outputs:
  - IDLE: `game_reset`=1. `start_edge` goes to READY.
  - READY: `game_reset`=1; `score` cleared on entry. `flap_edge` goes to PLAY and sets `flap_pend`.
  - PLAY: `phys_enable`=1. `hit = pipe_hit | (bird_y >= FLOOR_Y) | bird_y[10]`, where bit 10 marks underflow above the top.
    - `hit` on any cycle goes to DYING next cycle.
  - DYING: `collision`=1. The death counter clears on entry and increments on each `frame_tick`. On the tick that makes the count equal `DEATH_FRAMES`, go to OVER.
  - OVER: `collision`=1, `game_over`=1. `start_edge` goes to READY.
- Flap:
  - `flap_edge` in PLAY sets `flap_pend`.
  - On `frame_tick` with `flap_pend` set, `flap`=1 for that cycle and `flap_pend` clears.
  - Several presses between ticks collapse into one flap.
  - Presses in IDLE, DYING and OVER are discarded. `flap_pend` clears on leaving PLAY.
- Score:
  - Increments on `pipe_passed` in PLAY only, and not on a cycle where `hit`=1.
  - Saturates at 2^`SCORE_W`-1. Holds through DYING and OVER.
- Outputs not listed for a state are 0.

## Timing
- Reset values:
  - State IDLE; `game_reset`=1.
  - `phys_enable`, `flap`, `collision`, `game_over`, `frame_tick` = 0.
  - `score`, `high_score`, tick and death counters = 0; `flap_pend`=0.
- State-decoded outputs (`game_reset`, `phys_enable`, `collision`, `game_over`) change the cycle after the triggering edge.
- `flap` is registered and appears in the same cycle as `frame_tick`.
- READY→PLAY: `phys_enable` rises and `game_reset` falls in the same cycle. The starting press flaps on the first tick in PLAY.
- Same-cycle `hit` and `pipe_passed`: `hit` wins, no increment.
- `flap_edge` and `hit` in the same PLAY cycle: go to DYING, no flap issued.
- An asynchronous reset mid-game returns everything to reset values immediately.

## Configuration
- `HIGH_SCORE_EN` defined:
  - `high_score` is a register.
  - On the cycle of the DYING→OVER transition, `high_score` loads `score` if `score > high_score`.
  - Cleared only by `reset`.
- `HIGH_SCORE_EN` undefined: the `high_score` port exists and is tied to 0; no register.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEATH_FRAMES`=3, `FLOOR_Y`=460, `SCORE_W`=4.
- Reset released with `start`=1 held:
  - Required: stays IDLE, `game_reset`=1, `frame_tick` pulses every 4 cycles.
  - Release `start`, then press again: READY next cycle.
- From READY, press `flap_btn` for 1 cycle:
  - Required: PLAY next cycle, `phys_enable`=1.
  - `flap`=1 exactly at the next `frame_tick`.
  - Three presses within one tick window: a single `flap` pulse.
- In PLAY, 3 `pipe_passed` pulses, then `pipe_hit`:
  - Required: `score`=3, DYING next cycle, `collision`=1.
  - OVER after 3 ticks, `game_over`=1.
- In PLAY, `bird_y`=460 and, separately, `bird_y`=11'h7FE:
  - Required: DYING next cycle in each case.
  - `pipe_passed` in the same cycle as `hit`: `score` unchanged.
- 17 `pipe_passed` pulses: `score` saturates at 15.
  - With `HIGH_SCORE_EN`: `high_score`=15 after OVER.
  - Next game scoring 2: `high_score` stays 15. Without the macro: `high_score`=0 throughout.
- `reset` asserted mid-DYING: all outputs return to reset values asynchronously; state IDLE.
